// File: rtl/vid_pkg.sv
// Shared types for the image BRAM arbiter: arbiter state encoding and the
// read-return tag that says which requester a pending read belongs to.
package vid_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_VID  = 2'd1,
    ARB_HOST = 2'd2
  } arb_state_t;

  typedef enum logic {
    TAG_VID  = 1'b0,
    TAG_HOST = 1'b1
  } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid/tag shift register that follows each accepted read through the BRAM
// so its data can be steered to the right requester when it comes back.
module rd_tag_pipe
  import vid_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  tag_t in_tag,
  output logic out_valid,
  output tag_t out_tag
);

  logic [DEPTH-1:0] vld_q;
  tag_t             tag_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= TAG_VID;
    end else begin
      vld_q    <= {vld_q[DEPTH-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/img_bram_arb.sv
// Arbitrates one BRAM port between the video prefetcher and the host image
// loader with urgent-video override, burst limiting and round-robin from idle.
module img_bram_arb
  import vid_pkg::*;
#(
  parameter int ADDRW     = 17,
  parameter int DATAW     = 24,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_req,
  input  logic [ADDRW-1:0] v_addr,
  input  logic             v_urgent,
  output logic             v_gnt,
  output logic [DATAW-1:0] v_rdata,
  output logic             v_rvalid,
  input  logic             h_req,
  input  logic             h_we,
  input  logic [ADDRW-1:0] h_addr,
  input  logic [DATAW-1:0] h_wdata,
  output logic             h_gnt,
  output logic [DATAW-1:0] h_rdata,
  output logic             h_rvalid,
  output logic             bram_en,
  output logic             bram_we,
  output logic [ADDRW-1:0] bram_addr,
  output logic [DATAW-1:0] bram_wdata,
  input  logic [DATAW-1:0] bram_rdata,
  output arb_state_t       dbg_state
);

  localparam int              CNTW    = $clog2(BURST_MAX + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BURST_MAX);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  // Handshake: a requester holds req (and its address/data) until it sees
  // gnt in the same cycle; req && gnt is the single point of acceptance.
  arb_state_t      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rr_vid_q, rr_vid_d;
  logic            gnt_v, gnt_h;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    gnt_v    = 1'b0;
    gnt_h    = 1'b0;
    state_d  = ARB_IDLE;
    cnt_d    = '0;
    rr_vid_d = rr_vid_q;
    if (!rst) begin
      if (v_urgent && v_req) begin
        gnt_v = 1'b1;
      end else if (v_req && h_req) begin
        case (state_q)
          ARB_IDLE: if (rr_vid_q) gnt_v = 1'b1; else gnt_h = 1'b1;
          ARB_VID:  if (cnt_q < CNT_MAX) gnt_v = 1'b1; else gnt_h = 1'b1;
          ARB_HOST: if (cnt_q < CNT_MAX) gnt_h = 1'b1; else gnt_v = 1'b1;
          default:  gnt_v = 1'b1;
        endcase
      end else begin
        gnt_v = v_req;
        gnt_h = h_req;
      end

      // Continuing the same owner extends its burst; any hand-over restarts it.
      if (gnt_v) begin
        state_d  = ARB_VID;
        cnt_d    = (state_q == ARB_VID) ? cnt_inc : CNT_ONE;
        rr_vid_d = 1'b0;
      end else if (gnt_h) begin
        state_d  = ARB_HOST;
        cnt_d    = (state_q == ARB_HOST) ? cnt_inc : CNT_ONE;
        rr_vid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      rr_vid_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_vid_q <= rr_vid_d;
    end
  end

  logic             en_q, we_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      en_q    <= gnt_v | gnt_h;
      we_q    <= gnt_h & h_we;
      addr_q  <= gnt_v ? v_addr : (gnt_h ? h_addr : '0);
      wdata_q <= (gnt_h && h_we) ? h_wdata : '0;
    end
  end

  logic pipe_valid;
  tag_t pipe_tag;

  rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (gnt_v | (gnt_h & ~h_we)),
    .in_tag   (gnt_v ? TAG_VID : TAG_HOST),
    .out_valid(pipe_valid),
    .out_tag  (pipe_tag)
  );

  // Outputs are forced low while rst is held, even before the reset edge.
  assign v_gnt      = gnt_v;
  assign h_gnt      = gnt_h;
  assign bram_en    = en_q & ~rst;
  assign bram_we    = we_q & ~rst;
  assign bram_addr  = rst ? '0 : addr_q;
  assign bram_wdata = rst ? '0 : wdata_q;
  assign v_rvalid   = pipe_valid & ~rst & (pipe_tag == TAG_VID);
  assign h_rvalid   = pipe_valid & ~rst & (pipe_tag == TAG_HOST);
  assign v_rdata    = v_rvalid ? bram_rdata : '0;
  assign h_rdata    = h_rvalid ? bram_rdata : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_img_bram_arb.sv
// Directed plus randomized bench for img_bram_arb with a BRAM model and a
// transaction-level reference of the arbitration and read-return rules.
module tb_img_bram_arb;
  import vid_pkg::*;

  localparam int ADDRW = 17;
  localparam int DATAW = 24;
  localparam int BURST = 16;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst, v_req, v_urgent, h_req, h_we;
  logic [ADDRW-1:0] v_addr, h_addr, bram_addr;
  logic [DATAW-1:0] h_wdata, v_rdata, h_rdata, bram_wdata, bram_rdata;
  logic             v_gnt, h_gnt, v_rvalid, h_rvalid, bram_en, bram_we;
  arb_state_t       dbg_state;

  img_bram_arb #(.ADDRW(ADDRW), .DATAW(DATAW), .RD_LAT(LAT), .BURST_MAX(BURST)) dut (
    .clk(clk), .rst(rst),
    .v_req(v_req), .v_addr(v_addr), .v_urgent(v_urgent), .v_gnt(v_gnt),
    .v_rdata(v_rdata), .v_rvalid(v_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // BRAM model: write on enable, read data appears LAT cycles after enable.
  logic [DATAW-1:0] bram_mem [256];
  logic [DATAW-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (bram_en && bram_we) bram_mem[bram_addr[7:0]] <= bram_wdata;
    rd1 <= bram_mem[bram_addr[7:0]];
    rd2 <= rd1;
  end
  assign bram_rdata = rd2;

  // Reference: owner of the running burst, its length, who wins from idle.
  typedef struct {
    int               due;
    bit               is_v;
    logic [DATAW-1:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  logic [DATAW-1:0] ref_mem [256];
  int               owner, run, cyc;
  bit               pref_v;
  logic             nxt_en, nxt_we;
  logic [ADDRW-1:0] nxt_addr;
  logic [DATAW-1:0] nxt_wdata;
  int               vectors, miscompares;
  logic             s_v_gnt, s_h_gnt, s_v_rvalid, s_h_rvalid;
  logic [DATAW-1:0] s_h_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // 0 = nobody, 1 = video, 2 = host
  function automatic int predict(input logic r, input logic vr, input logic vu, input logic hr);
    if (r) return 0;
    if (vu && vr) return 1;
    if (vr && hr) begin
      if (owner == 0) return pref_v ? 1 : 2;
      if (run < BURST) return owner;
      return 3 - owner;
    end
    if (vr) return 1;
    if (hr) return 2;
    return 0;
  endfunction

  task automatic cycle(input logic r, input logic vr, input logic vu, input logic hr,
                       input logic hwe, input logic [ADDRW-1:0] va,
                       input logic [ADDRW-1:0] ha, input logic [DATAW-1:0] hwd);
    int               g;
    logic             erv, ehv;
    logic [DATAW-1:0] evd, ehd;
    rd_exp_t          ent;
    rst = r; v_req = vr; v_urgent = vu; h_req = hr; h_we = hwe;
    v_addr = va; h_addr = ha; h_wdata = hwd;
    g = predict(r, vr, vu, hr);
    erv = 1'b0; ehv = 1'b0; evd = '0; ehd = '0;
    if (!r && exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ent = exp_q.pop_front();
      if (ent.is_v) begin erv = 1'b1; evd = ent.data; end
      else begin ehv = 1'b1; ehd = ent.data; end
    end
    @(negedge clk);
    check("v_gnt", 32'(v_gnt), 32'(g == 1));
    check("h_gnt", 32'(h_gnt), 32'(g == 2));
    check("bram_en", 32'(bram_en), r ? 32'd0 : 32'(nxt_en));
    check("bram_we", 32'(bram_we), r ? 32'd0 : 32'(nxt_we));
    check("bram_addr", 32'(bram_addr), r ? 32'd0 : 32'(nxt_addr));
    check("bram_wdata", 32'(bram_wdata), r ? 32'd0 : 32'(nxt_wdata));
    check("v_rvalid", 32'(v_rvalid), 32'(erv));
    check("h_rvalid", 32'(h_rvalid), 32'(ehv));
    check("v_rdata", 32'(v_rdata), 32'(evd));
    check("h_rdata", 32'(h_rdata), 32'(ehd));
    s_v_gnt = v_gnt; s_h_gnt = h_gnt; s_v_rvalid = v_rvalid;
    s_h_rvalid = h_rvalid; s_h_rdata = h_rdata;
    if (r) begin
      exp_q.delete();
      nxt_en = 1'b0; nxt_we = 1'b0; nxt_addr = '0; nxt_wdata = '0;
      owner = 0; run = 0; pref_v = 1'b1;
    end else begin
      nxt_en    = (g != 0);
      nxt_addr  = (g == 1) ? va : ((g == 2) ? ha : '0);
      nxt_we    = (g == 2) && hwe;
      nxt_wdata = nxt_we ? hwd : '0;
      if (g == 1) exp_q.push_back('{cyc + 1 + LAT, 1'b1, ref_mem[va[7:0]]});
      if (g == 2 && !hwe) exp_q.push_back('{cyc + 1 + LAT, 1'b0, ref_mem[ha[7:0]]});
      if (g == 2 && hwe) ref_mem[ha[7:0]] = hwd;
      if (g == 0) begin owner = 0; run = 0; end
      else begin
        run    = (g == owner) ? ((run < BURST) ? run + 1 : BURST) : 1;
        owner  = g;
        pref_v = (g == 2);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    int cnt, vcnt;
    vectors = 0; miscompares = 0; cyc = 0;
    owner = 0; run = 0; pref_v = 1'b1;
    nxt_en = 1'b0; nxt_we = 1'b0; nxt_addr = '0; nxt_wdata = '0;
    for (int i = 0; i < 256; i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; v_req = 1'b0; v_urgent = 1'b0; h_req = 1'b0; h_we = 1'b0;
    v_addr = '0; h_addr = '0; h_wdata = '0;
    @(posedge clk);
    #1;

    // Reset with both requesting: nothing granted, state idle.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 17'd1, 17'd2, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 17'd1, 17'd2, '0);
    check("reset_state", 32'(dbg_state), 32'(ARB_IDLE));

    // Both continuous: 16 video, 16 host, alternating.
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17'(i), 17'(100 + i), '0);
      check("burst_alt_v", 32'(s_v_gnt), 32'(((i / BURST) % 2) == 0));
    end
    idle(5);

    // Urgent video holds off the host; host wins the cycle urgent drops.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 17'(i), 17'(i), '0);
      check("urgent_v", 32'(s_v_gnt), 32'd1);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17'd7, 17'd8, '0);
    check("urgent_release_h", 32'(s_h_gnt), 32'd1);
    idle(5);

    // After a video grant and an idle cycle, host goes first.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'd9, '0, '0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17'd10, 17'd11, '0);
    check("rr_from_idle_h", 32'(s_h_gnt), 32'd1);
    idle(5);

    // Host write then read back.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 17'd5, 24'hABCDEF);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 17'd5, '0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check("wr_rd_no_vrvalid", 32'(s_v_rvalid), 32'd0);
      if (k == LAT + 1) begin
        check("wr_rd_h_rvalid", 32'(s_h_rvalid), 32'd1);
        check("wr_rd_h_rdata", 32'(s_h_rdata), 32'hABCDEF);
      end
    end

    // Lone host: granted every cycle.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 17'(i), '0);
      if (s_h_gnt) cnt++;
    end
    check("lone_host_grants", 32'(cnt), 32'd40);
    check("lone_host_state", 32'(dbg_state), 32'(ARB_HOST));
    idle(5);

    // In-flight video reads discarded by reset.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'(i), '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (s_v_rvalid) vcnt++;
    end
    check("reset_drops_reads", 32'(vcnt), 32'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), 17'($urandom_range(0, 255)),
            17'($urandom_range(0, 255)), 24'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/img_bram_arb.md
IMG_BRAM_ARB -- requirements
Module: img_bram_arb

Interface
REQ-001 Parameter ADDRW, default 17, BRAM address width.
REQ-002 Parameter DATAW, default 24, pixel/BRAM data width.
REQ-003 Parameter RD_LAT, default 2, BRAM read latency in cycles, from bram_en to valid bram_rdata (range 1-4).
REQ-004 Parameter BURST_MAX, default 16, maximum consecutive grants to one requester while the other is requesting.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 v_req  in  1  video prefetch read request.
REQ-008 v_addr  in  ADDRW  video read address.
REQ-009 v_urgent  in  1  video FIFO low; strict video priority when high.
REQ-010 v_gnt  out  1  video request accepted this cycle.
REQ-011 v_rdata  out  DATAW  video read data.
REQ-012 v_rvalid  out  1  v_rdata valid.
REQ-013 h_req  in  1  host (image loader) request.
REQ-014 h_we  in  1  host write when 1, read when 0.
REQ-015 h_addr  in  ADDRW  host address.
REQ-016 h_wdata  in  DATAW  host write data.
REQ-017 h_gnt  out  1  host request accepted this cycle.
REQ-018 h_rdata  out  DATAW  host read data.
REQ-019 h_rvalid  out  1  h_rdata valid.
REQ-020 bram_en, bram_we  out  1 each  BRAM port enable and write enable.
REQ-021 bram_addr  out  ADDRW;  bram_wdata  out  DATAW;  bram_rdata  in  DATAW.

Function
REQ-022 Acceptance occurs on a cycle with req && gnt; at most one of v_gnt, h_gnt is high per cycle; gnt is never high without its req.
REQ-023 An accepted request drives bram_en=1, bram_addr, and bram_we/bram_wdata (host write only) registered, on the cycle after acceptance; bram_en=0 on all other cycles.
REQ-024 A read returns xx_rvalid=1 exactly 1+RD_LAT cycles after acceptance, with xx_rdata=bram_rdata; host writes produce no rvalid.
REQ-025 Back-to-back acceptances at one per cycle are supported; rvalids are in order and tagged to the correct requester.
REQ-026 State machine states: ARB_IDLE, ARB_VID, ARB_HOST. The state names the owner of the last grant; ARB_IDLE means no grant on the previous cycle.
REQ-027 If v_urgent=1 and v_req=1, grant video regardless of state or burst count.
REQ-028 Otherwise, from ARB_IDLE with both requesting, grant the requester not served most recently (rr pointer; video after reset).
REQ-029 In ARB_VID/ARB_HOST, the owner keeps the grant while requesting and its burst count < BURST_MAX; when the count reaches BURST_MAX and the other requests, the grant switches and the count restarts at 1.
REQ-030 A lone requester is granted every cycle, with no burst limit; the count saturates at BURST_MAX.
REQ-031 Go to ARB_IDLE when neither requests; the burst count clears to 0.
REQ-032 Burst counter width is clog2(BURST_MAX+1); it never wraps.

Reset
REQ-033 On rst: state=ARB_IDLE, rr pointer=video, burst count=0, tag pipeline cleared.
REQ-034 On rst, all outputs are 0: v_gnt, h_gnt, v_rvalid, h_rvalid, bram_en, bram_we, bram_addr, bram_wdata, v_rdata, h_rdata.
REQ-035 Reset mid-operation discards in-flight reads; no rvalid is asserted for requests accepted before or during reset.
REQ-036 gnt is 0 while rst=1.

Structure
REQ-037 vid_pkg holds arb_state_t (ARB_IDLE, ARB_VID, ARB_HOST) and the tag encoding (TAG_VID, TAG_HOST).
REQ-038 Sub-module rd_tag_pipe: RD_LAT+1 deep valid/tag shift register, synchronous reset, one instance.

Verification
REQ-039 v_req continuous, h_req continuous, v_urgent=0 -> 16 video grants, then 16 host grants, alternating; rvalid follows each read at +3 cycles with RD_LAT=2.
REQ-040 Both requests held, v_urgent=1 -> only v_gnt=1 until v_urgent drops; the host is then granted on the next cycle.
REQ-041 Host writes 0xABCDEF to addr 5, then host reads addr 5 -> h_rvalid=1 with h_rdata=0xABCDEF 3 cycles after read acceptance; no v_rvalid.
REQ-042 Only h_req for 40 cycles -> 40 consecutive h_gnt, no switch, count saturates at 16.
REQ-043 Video reads at addrs 0-3 accepted, rst pulsed 1 cycle after the last acceptance -> zero v_rvalid afterwards; all outputs 0 during reset.
REQ-044 Both requesting from ARB_IDLE after the last grant went to video -> host granted first.
